// File: rtl/mul_div_unit.sv
// Iterative 32-bit multiply/divide unit with HI/LO result registers.
// Shift-add multiply and restoring divide, one bit per cycle over 32 cycles.
module mul_div_unit (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [1:0]  Op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [31:0] Wd,
  input  logic        Hiwrite,
  input  logic        Lowrite,
  output logic        Busy,
  output logic [31:0] Hi,
  output logic [31:0] Lo
);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t      state;
  logic [5:0]  cnt;
  logic        is_div;
  logic        neg_q;
  logic        neg_r;
  logic        div0;
  logic [31:0] a_raw;
  logic [31:0] b_mag;
  logic [63:0] acc;

  logic        sgn;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_abs;
  logic [31:0] b_abs;

  always_comb begin
    sgn   = ~Op[0];
    a_neg = sgn & A[31];
    b_neg = sgn & B[31];
    a_abs = a_neg ? -A : A;
    b_abs = b_neg ? -B : B;
  end

  logic [32:0] mul_sum;
  logic [63:0] mul_nx;
  logic [32:0] shl;
  logic [33:0] diff;
  logic        q_bit;
  logic [31:0] rem_nx;
  logic [63:0] div_nx;
  logic [63:0] acc_nx;

  // acc = {partial/remainder, multiplier/quotient}
  always_comb begin
    mul_sum = {1'b0, acc[63:32]}
            + (acc[0] ? {1'b0, b_mag} : 33'd0);
    mul_nx  = {mul_sum, acc[31:1]};
    shl     = {acc[63:32], acc[31]};
    diff    = {1'b0, shl} - {2'b0, b_mag};
    q_bit   = ~diff[33];
    rem_nx  = q_bit ? diff[31:0] : shl[31:0];
    div_nx  = {rem_nx, acc[30:0], q_bit};
    acc_nx  = is_div ? div_nx : mul_nx;
  end

  logic [63:0] prod;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [31:0] res_hi;
  logic [31:0] res_lo;

  always_comb begin
    prod = neg_q ? -acc_nx : acc_nx;
    quo  = neg_q ? -acc_nx[31:0] : acc_nx[31:0];
    rem  = neg_r ? -acc_nx[63:32] : acc_nx[63:32];
    res_hi = prod[63:32];
    res_lo = prod[31:0];
    if (is_div) begin
      res_hi = div0 ? a_raw : rem;
      res_lo = div0 ? 32'hFFFF_FFFF : quo;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state  <= IDLE;
      Busy   <= 1'b0;
      Hi     <= '0;
      Lo     <= '0;
      cnt    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      div0   <= 1'b0;
      a_raw  <= '0;
      b_mag  <= '0;
      acc    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (Hiwrite) Hi <= Wd;
          if (Lowrite) Lo <= Wd;
          if (Start) begin
            state  <= RUN;
            Busy   <= 1'b1;
            cnt    <= 6'd32;
            is_div <= Op[1];
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            div0   <= (B == 32'd0);
            a_raw  <= A;
            b_mag  <= b_abs;
            acc    <= {32'd0, a_abs};
          end
        end
        RUN: begin
          acc <= acc_nx;
          cnt <= cnt - 6'd1;
          if (cnt == 6'd1) begin
            state <= IDLE;
            Busy  <= 1'b0;
            Hi    <= res_hi;
            Lo    <= res_lo;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative multiply/divide unit with HI/LO result registers for the MIPS-Lite4 datapath. It sits directly downstream of the GPR read ports: Rd1/Rd2 feed its operand inputs for MULT/MULTU/DIV/DIVU, and Wd feeds it for MTHI/MTLO. Hi/Lo drive the MFHI/MFLO path back toward GPR write-back. Busy lets the controller stall any instruction that touches HI/LO while an operation runs.

## Interface
Parameters:
- none; the datapath width is fixed at 32 bits.

Ports:
- Clk  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  launch request; sampled only when Busy=0.
- Op  in  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- A  in  32  operand rs (from GPR Rd1); the dividend for divides.
- B  in  32  operand rt (from GPR Rd2); the divisor for divides.
- Wd  in  32  data for MTHI/MTLO.
- Hiwrite  in  1  MTHI strobe.
- Lowrite  in  1  MTLO strobe.
- Busy  out  1  operation in progress.
- Hi  out  32  HI register.
- Lo  out  32  LO register.

## Operation
- Reset values: Busy=0, Hi=0, Lo=0. The iteration counter and internal operand/accumulator registers are also cleared.
- States:
  - IDLE -> RUN on a rising edge where Start=1 and Busy=0.
  - RUN -> IDLE after 32 iteration cycles.
- On the launch edge, latch A, B and Op, and load the counter with 32.
  - Signed ops (MULT, DIV): convert operands to magnitudes and latch the result sign bits.
- Multiply: shift-add, one bit per cycle, into a 64-bit accumulator.
  - Result {Hi,Lo} is the 64-bit product.
  - Signed products are two's-complement negated when the operand signs differ.
- Divide: restoring division, one quotient bit per cycle. Lo = quotient, Hi = remainder.
  - Signed: the quotient truncates toward zero; the remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF (DIV): Lo=0x80000000, Hi=0. No exception is raised.
  - Divide by zero (both DIV and DIVU): Lo=0xFFFFFFFF, Hi=A as latched. No exception is raised.
- Hi and Lo hold their previous values throughout RUN. They update only on the completion edge.
- Hiwrite/Lowrite are honoured only when Busy=0. Hi (or Lo) takes Wd on that edge. When Busy=1 they are ignored.
- Start while Busy=1 is ignored: no restart and no queuing.
- Start together with Hiwrite/Lowrite while idle:
  - Both are honoured on that edge.
  - The operation result later overwrites both Hi and Lo.
- Op values are all defined; there is no illegal encoding.
- Reset mid-operation aborts the operation. Partial results are discarded, and Hi=Lo=0 after the reset edge.

## Timing
- Edge 0: Start=1 is sampled with Busy=0. Busy reads 1 after edge 0.
- Edges 1..32: one iteration per edge.
- Edge 32: Hi/Lo are written and Busy drops to 0 on the same edge.
  - Busy is high for exactly 32 cycles.
  - Results are visible the cycle after edge 32.
- Back-to-back launch: a new Start can be accepted on the edge after edge 32. Minimum issue interval is 33 cycles.
- A, B and Op may change freely after edge 0. Changes during RUN have no effect.
- MTHI/MTLO latency: 1 edge. The new Hi/Lo is readable the next cycle.
- Hi/Lo are registered outputs, not combinational from the inputs.
- Reset has priority over every other input on the same edge.

## Test plan
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> Busy high exactly 32 cycles, then Hi=0xFFFFFFFE, Lo=0x00000001.
- MULT A=0xFFFFFFFD (-3), B=5 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFF1.
  - Then DIV A=0xFFFFFFF9 (-7), B=2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF.
  - Then DIVU A=7, B=2 -> Lo=3, Hi=1.
- Corner divides:
  - DIVU A=0x1234, B=0 -> Hi=0x1234, Lo=0xFFFFFFFF.
  - DIV A=0x80000000, B=0xFFFFFFFF -> Lo=0x80000000, Hi=0.
- Idle MTHI/MTLO: Hiwrite with Wd=0xDEADBEEF -> Hi=0xDEADBEEF the next cycle. Lowrite with Wd=0x0BADF00D -> Lo=0x0BADF00D.
- Ignored inputs while busy:
  - Launch MULTU 3*4.
  - At busy cycle 5, assert Start with different operands, plus Hiwrite with Wd=0x55 -> both ignored.
  - Final Hi=0, Lo=12. Busy still falls at edge 32.
- Reset mid-operation:
  - Launch DIVU 100/7, then assert Reset at busy cycle 10 -> Busy=0, Hi=Lo=0 after that edge.
  - Start DIVU 100/7 on the next cycle -> Lo=14, Hi=2 after 32 busy cycles.
